// File: rtl/stride_read_master.sv
// Strided AXI read-burst master: issues cfg_count bursts at base + n*stride, checks R beats, XORs data.
// Define STRIDE_READ_MASTER_STALL_CNT_EN to add the stall_cnt output.
module stride_read_master #(
  parameter int ADDR_BITS            = 16,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 0,
  parameter int MAX_OUTSTANDING      = 4,
  parameter int CNT_WIDTH            = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_BITS-1:0]                cfg_base,
  input  logic [ADDR_BITS-1:0]                cfg_stride,
  input  logic [CNT_WIDTH-1:0]                cfg_count,
  input  logic [BURST_LEN_WIDTH-1:0]          cfg_len,
  input  logic [TID_WIDTH-1:0]                cfg_id,
  output logic                                m_ar_valid,
  input  logic                                m_ar_ready,
  output logic [ADDR_BITS-1:0]                m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]          m_ar_len,
  output logic [TID_WIDTH-1:0]                m_ar_id,
  input  logic                                m_r_valid,
  output logic                                m_r_ready,
  input  logic                                m_r_last,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] m_r_data,
  input  logic [TID_WIDTH-1:0]                m_r_id,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] checksum
`ifdef STRIDE_READ_MASTER_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH+7:0]                stall_cnt
`endif
);

  localparam int DATA_WIDTH = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                     state, state_n;
  logic [CNT_WIDTH-1:0]       count_q, issued, issued_n;
  logic [ADDR_BITS-1:0]       stride_q;
  logic [BURST_LEN_WIDTH-1:0] len_q, beat;
  logic [TID_WIDTH-1:0]       id_q;
  logic [OUT_W-1:0]           outstanding, out_n;
  logic                       ar_hs, r_hs, rlast_hs, r_err, out_dec;

  assign m_ar_len  = len_q;
  assign m_ar_id   = id_q;
  assign m_r_ready = busy;

  always_comb begin
    ar_hs    = m_ar_valid & m_ar_ready;
    r_hs     = m_r_valid & m_r_ready;
    rlast_hs = r_hs & m_r_last;
    out_dec  = rlast_hs && (outstanding != '0);
    issued_n = issued + CNT_WIDTH'(ar_hs);
    out_n    = outstanding + OUT_W'(ar_hs) - OUT_W'(out_dec);
    r_err    = r_hs && ((m_r_id != id_q) ||
                        (m_r_last && (beat != len_q)) ||
                        (!m_r_last && (beat == len_q)) ||
                        (outstanding == '0));
    state_n  = state;
    case (state)
      S_IDLE:  if (start) state_n = (cfg_count == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (ar_hs && (issued_n == count_q)) state_n = (out_n == '0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (out_n == '0) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next-cycle counts feed the registered valid/done so done lands one cycle after the final handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      m_ar_valid  <= 1'b0;
      m_ar_addr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      checksum    <= '0;
      outstanding <= '0;
      issued      <= '0;
      beat        <= '0;
      count_q     <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      id_q        <= '0;
`ifdef STRIDE_READ_MASTER_STALL_CNT_EN
      stall_cnt   <= '0;
`endif
    end else begin
      state <= state_n;
      busy  <= (state_n == S_ISSUE) || (state_n == S_DRAIN);
      done  <= (state_n == S_DONE);
      if (state == S_IDLE) begin
        m_ar_valid <= 1'b0;
        if (start) begin
          m_ar_addr   <= cfg_base;
          stride_q    <= cfg_stride;
          count_q     <= cfg_count;
          len_q       <= cfg_len;
          id_q        <= cfg_id;
          error       <= 1'b0;
          checksum    <= '0;
          issued      <= '0;
          outstanding <= '0;
          beat        <= '0;
          m_ar_valid  <= (cfg_count != '0);
        end
      end else begin
        issued      <= issued_n;
        outstanding <= out_n;
        if (ar_hs) m_ar_addr <= m_ar_addr + stride_q;
        // A stalled request keeps valid: issued is unchanged and outstanding cannot grow.
        m_ar_valid  <= (state_n == S_ISSUE) && (out_n < OUT_W'(MAX_OUTSTANDING)) &&
                       (issued_n < count_q);
        if (r_hs) begin
          checksum <= checksum ^ DATA_WIDTH'(m_r_data);
          if (m_r_last)            beat <= '0;
          else if (beat != len_q)  beat <= beat + BURST_LEN_WIDTH'(1);
        end
        if (r_err) error <= 1'b1;
      end
`ifdef STRIDE_READ_MASTER_STALL_CNT_EN
      if ((state == S_IDLE) && start) begin
        stall_cnt <= '0;
      end else if (((m_ar_valid && !m_ar_ready) ||
                    ((state == S_ISSUE) && (outstanding == OUT_W'(MAX_OUTSTANDING)))) &&
                   (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + (CNT_WIDTH+8)'(1);
      end
`endif
    end
  end

endmodule
